// File: rtl/barrett_mm_ctrl.sv
// Two-requester round-robin controller that drives a multi-cycle combinational Barrett datapath
// and holds each result until it is taken. Optional op_count output: define BARRETT_CTRL_CNT_EN.
module barrett_mm_ctrl #(
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [63:0] req0_a,
   input  logic [63:0] req0_b,
   input  logic [63:0] req1_a,
   input  logic [63:0] req1_b,
   input  logic [63:0] cfg_q,
   input  logic [7:0]  cfg_mu,
   input  logic [13:0] cfg_r,
   output logic [63:0] dp_a,
   output logic [63:0] dp_b,
   output logic [63:0] dp_q,
   output logic [7:0]  dp_mu,
   output logic [13:0] dp_r,
   input  logic [63:0] dp_t,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_t,
   output logic        rsp_id,
`ifdef BARRETT_CTRL_CNT_EN
   output logic [31:0] op_count,
`endif
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETTLE = 2'b01,
      ST_HOLD   = 2'b10
   } state_t;

   localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYC - 1);

   state_t      state_r;
   state_t      state_next_s;
   logic [7:0]  cnt_r;
   logic        rr_r;
   logic        grant_s;
   logic        accept_s;
   logic        done_s;
   logic        hs_s;
   logic [63:0] dp_a_r;
   logic [63:0] dp_b_r;
   logic [63:0] dp_q_r;
   logic [7:0]  dp_mu_r;
   logic [13:0] dp_r_r;
   logic [63:0] rsp_t_r;
   logic        rsp_id_r;
   logic        rsp_valid_r;
   logic        busy_r;

   // Next-state, grant selection and handshake decode.
   always_comb begin
      state_next_s = state_r;
      grant_s      = rr_r;
      accept_s     = 1'b0;
      done_s       = 1'b0;
      hs_s         = 1'b0;
      // The preferred requester keeps the grant unless only the other one is valid.
      if (rr_r == 1'b0) begin
         grant_s = (!req0_valid && req1_valid) ? 1'b1 : 1'b0;
      end else begin
         grant_s = (!req1_valid && req0_valid) ? 1'b0 : 1'b1;
      end
      case (state_r)
         ST_IDLE: begin
            if ((grant_s == 1'b0) ? req0_valid : req1_valid) begin
               accept_s     = 1'b1;
               state_next_s = ST_SETTLE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == 8'd0) begin
               done_s       = 1'b1;
               state_next_s = ST_HOLD;
            end else begin
               state_next_s = ST_SETTLE;
            end
         end
         ST_HOLD: begin
            if (rsp_ready && rsp_valid_r) begin
               hs_s         = 1'b1;
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_HOLD;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != ST_IDLE);
      end
   end

   // Settle counter and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
         rr_r  <= 1'b0;
      end else if (accept_s) begin
         cnt_r <= CNT_LOAD;
         rr_r  <= ~grant_s;
      end else if ((state_r == ST_SETTLE) && (cnt_r != 8'd0)) begin
         cnt_r <= cnt_r - 8'd1;
      end
   end

   // Operand and configuration snapshot; cfg edits after accept do not reach the datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dp_a_r   <= 64'd0;
         dp_b_r   <= 64'd0;
         dp_q_r   <= 64'd0;
         dp_mu_r  <= 8'd0;
         dp_r_r   <= 14'd0;
         rsp_id_r <= 1'b0;
      end else if (accept_s) begin
         dp_a_r   <= (grant_s == 1'b0) ? req0_a : req1_a;
         dp_b_r   <= (grant_s == 1'b0) ? req0_b : req1_b;
         dp_q_r   <= cfg_q;
         dp_mu_r  <= cfg_mu;
         dp_r_r   <= cfg_r;
         rsp_id_r <= grant_s;
      end
   end

   // Result capture once settled; valid drops only on the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_t_r     <= 64'd0;
         rsp_valid_r <= 1'b0;
      end else if (done_s) begin
         rsp_t_r     <= dp_t;
         rsp_valid_r <= 1'b1;
      end else if (hs_s) begin
         rsp_valid_r <= 1'b0;
      end
   end

`ifdef BARRETT_CTRL_CNT_EN
   logic [31:0] op_count_r;

   // Completed-handshake counter, wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_r <= 32'd0;
      end else if (hs_s) begin
         op_count_r <= op_count_r + 32'd1;
      end
   end

   assign op_count = op_count_r;
`endif

   assign req0_ready = (state_r == ST_IDLE) && (grant_s == 1'b0);
   assign req1_ready = (state_r == ST_IDLE) && (grant_s == 1'b1);
   assign dp_a       = dp_a_r;
   assign dp_b       = dp_b_r;
   assign dp_q       = dp_q_r;
   assign dp_mu      = dp_mu_r;
   assign dp_r       = dp_r_r;
   assign rsp_t      = rsp_t_r;
   assign rsp_id     = rsp_id_r;
   assign rsp_valid  = rsp_valid_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_barrett_mm_ctrl.sv
// Directed bench for barrett_mm_ctrl with a modular-multiply datapath stub that only
// produces a defined result after its inputs have been stable for SETTLE_CYC cycles.
module tb_barrett_mm_ctrl;

   localparam int SETTLE_CYC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [63:0] req0_a, req0_b, req1_a, req1_b;
   logic [63:0] cfg_q;
   logic [7:0]  cfg_mu;
   logic [13:0] cfg_r;
   logic [63:0] dp_a, dp_b, dp_q, dp_t;
   logic [7:0]  dp_mu;
   logic [13:0] dp_r;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [63:0] rsp_t;
`ifdef BARRETT_CTRL_CNT_EN
   logic [31:0] op_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   barrett_mm_ctrl #(.SETTLE_CYC(SETTLE_CYC)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .cfg_q(cfg_q), .cfg_mu(cfg_mu), .cfg_r(cfg_r),
      .dp_a(dp_a), .dp_b(dp_b), .dp_q(dp_q), .dp_mu(dp_mu), .dp_r(dp_r),
      .dp_t(dp_t),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_t(rsp_t), .rsp_id(rsp_id),
`ifdef BARRETT_CTRL_CNT_EN
      .op_count(op_count),
`endif
      .busy(busy)
   );

   // Datapath stub: age counts mid-cycle samples since the inputs last changed.
   logic [63:0]  seen_a = 64'd0, seen_b = 64'd0, seen_q = 64'd0;
   logic [7:0]   age = 8'd0;
   logic [127:0] prod;
   always @(negedge clk) begin
      if (dp_a !== seen_a || dp_b !== seen_b || dp_q !== seen_q) begin
         seen_a <= dp_a;
         seen_b <= dp_b;
         seen_q <= dp_q;
         age    <= 8'd1;
      end else if (age != 8'd255) begin
         age <= age + 8'd1;
      end
   end
   assign prod = {64'd0, dp_a} * {64'd0, dp_b};
   assign dp_t = (age >= 8'(SETTLE_CYC) && dp_q != 64'd0) ?
                 64'(prod % {64'd0, dp_q}) : 64'hxxxx_xxxx_xxxx_xxxx;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input string tag, input logic exp_id, input logic [63:0] exp_t);
      int n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({tag, "_id"}, {63'd0, rsp_id}, {63'd0, exp_id});
      chk({tag, "_t"}, rsp_t, exp_t);
   endtask

   initial begin
      logic        any_valid;
      logic [63:0] exp_t [4];
      logic        exp_id [4];

      rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = 64'd0; req0_b = 64'd0; req1_a = 64'd0; req1_b = 64'd0;
      cfg_q = 64'd7681; cfg_mu = 8'd37; cfg_r = 14'd26; rsp_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_dp_a", dp_a, 64'd0);
      chk("rst_dp_q", dp_q, 64'd0);
      chk("rst_rsp_t", rsp_t, 64'd0);
      chk("rst_rdy0_idle", {63'd0, req0_ready}, 64'd1);
      chk("rst_rdy1_idle", {63'd0, req1_ready}, 64'd0);
      rst_n = 1'b1;
      tick();

      // Single op: 1467*2489 mod 7681 = 2888
      req0_a = 64'd1467; req0_b = 64'd2489; req0_valid = 1'b1; rsp_ready = 1'b1;
      #1;
      chk("s_rdy0", {63'd0, req0_ready}, 64'd1);
      chk("s_rdy1", {63'd0, req1_ready}, 64'd0);
      tick();
      req0_valid = 1'b0;
      chk("s_busy", {63'd0, busy}, 64'd1);
      chk("s_dp_a", dp_a, 64'd1467);
      chk("s_dp_b", dp_b, 64'd2489);
      chk("s_dp_q", dp_q, 64'd7681);
      chk("s_dp_mu", {56'd0, dp_mu}, 64'd37);
      chk("s_dp_r", {50'd0, dp_r}, 64'd26);
      chk("s_rdy_settle", {62'd0, req0_ready, req1_ready}, 64'd0);
      tick(); tick(); tick();
      chk("s_early_valid", {63'd0, rsp_valid}, 64'd0);
      // Accept edge is the first of SETTLE_CYC+1; this is the last one
      tick();
      chk("s_valid", {63'd0, rsp_valid}, 64'd1);
      chk("s_t", rsp_t, 64'd2888);
      chk("s_id", {63'd0, rsp_id}, 64'd0);
      tick();
      chk("s_valid_clr", {63'd0, rsp_valid}, 64'd0);
      chk("s_idle", {63'd0, busy}, 64'd0);

      // Config change after accept plus backpressure on requester 1
      req1_a = 64'd1467; req1_b = 64'd2489; req1_valid = 1'b1; rsp_ready = 1'b0;
      #1;
      chk("c_rdy1", {63'd0, req1_ready}, 64'd1);
      chk("c_rdy0", {63'd0, req0_ready}, 64'd0);
      tick();
      req1_valid = 1'b0;
      cfg_q = 64'd12289;
      tick(); tick(); tick();
      chk("c_dp_q", dp_q, 64'd7681);
      tick();
      chk("c_valid", {63'd0, rsp_valid}, 64'd1);
      chk("c_t", rsp_t, 64'd2888);
      chk("c_id", {63'd0, rsp_id}, 64'd1);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
         chk("bp_t", rsp_t, 64'd2888);
         chk("bp_dp_a", dp_a, 64'd1467);
         chk("bp_dp_q", dp_q, 64'd7681);
         chk("bp_rdy", {62'd0, req0_ready, req1_ready}, 64'd0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_rel_valid", {63'd0, rsp_valid}, 64'd0);
      chk("bp_rel_idle", {63'd0, busy}, 64'd0);
      chk("bp_rel_rdy", {62'd0, req0_ready, req1_ready}, 64'd2);
      req0_valid = 1'b0; req1_valid = 1'b0; cfg_q = 64'd7681;
      tick();

      // Reset in the second SETTLE cycle discards the op
      req0_a = 64'd100; req0_b = 64'd200; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk("r_busy", {63'd0, busy}, 64'd0);
      chk("r_valid", {63'd0, rsp_valid}, 64'd0);
      chk("r_dp_a", dp_a, 64'd0);
      chk("r_dp_q", dp_q, 64'd0);
      chk("r_rsp_t", rsp_t, 64'd0);
      tick();
      rst_n = 1'b1;
      any_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         any_valid = any_valid | rsp_valid | busy;
      end
      chk("r_no_rsp", {63'd0, any_valid}, 64'd0);
      req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      wait_rsp("r_next", 1'b0, 64'd4638);
      tick();

      // Contention from reset: grants alternate 0,1,0,1
      rst_n = 1'b0;
      req0_a = 64'd1467; req0_b = 64'd2489; req1_a = 64'd100; req1_b = 64'd200;
      req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
      exp_id[0] = 1'b0; exp_t[0] = 64'd2888;
      exp_id[1] = 1'b1; exp_t[1] = 64'd4638;
      exp_id[2] = 1'b0; exp_t[2] = 64'd1;
      exp_id[3] = 1'b1; exp_t[3] = 64'd4664;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_rsp($sformatf("rr%0d", i), exp_id[i], exp_t[i]);
         if (i == 1) begin
            req0_a = 64'd7680; req0_b = 64'd7680; req1_a = 64'd12345; req1_b = 64'd1;
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();

`ifdef BARRETT_CTRL_CNT_EN
      chk("cnt_four", {32'd0, op_count}, 64'd4);
      force dut.op_count_r = 32'hFFFF_FFFF;
      #1;
      release dut.op_count_r;
      req0_a = 64'd100; req0_b = 64'd200; req0_valid = 1'b1;
      tick();
      req0_valid = 1'b0;
      wait_rsp("cnt_op", 1'b0, 64'd4638);
      tick();
      chk("cnt_wrap", {32'd0, op_count}, 64'd0);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
